dense_sigmoid: RTL and testbench

DENSE_SIGMOID -- requirements
Module: dense_sigmoid

---
 rtl/dense_sigmoid_if.sv | 27 ++
 rtl/dense_sigmoid.sv | 145 ++++++++++++++
 tb/tb_dense_sigmoid.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_sigmoid_if.sv
// Bus bundle for dense_sigmoid: parameter write port, hidden-state stream in,
// activation result stream out, plus the busy flag.
interface dense_sigmoid_if #(
    parameter int LEN = 4,
    parameter int W   = 16
);
    logic                         wr_en;
    logic [$clog2(LEN+1)-1:0]     wr_addr;
    logic signed [W-1:0]          wr_data;
    logic                         h_valid;
    logic                         h_ready;
    logic signed [W-1:0]          h_data;
    logic                         y_valid;
    logic                         y_ready;
    logic [W-1:0]                 y_data;
    logic                         busy;

    modport master (
        output wr_en, wr_addr, wr_data, h_valid, h_data, y_ready,
        input  h_ready, y_valid, y_data, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, h_valid, h_data, y_ready,
        output h_ready, y_valid, y_data, busy
    );
endinterface

// File: rtl/dense_sigmoid.sv
// Single-neuron dense layer with hard-sigmoid activation.
// Accumulates LEN Q8.8 hidden-state elements against a writable weight file,
// adds a bias, rescales to Q8.8 with saturation and applies
// y = clamp(s/4 + 0.5, 0, 1) in Q8.8.
module dense_sigmoid #(
    parameter int LEN = 4,
    parameter int W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    dense_sigmoid_if.slave bus
);
    localparam int AW    = $clog2(LEN + 1);
    localparam int ACC_W = 2 * W + $clog2(LEN);
    localparam int SUM_W = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] S_MAX   = SUM_W'((2 ** (W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] S_MIN   = SUM_W'(-(2 ** (W - 1)));
    localparam logic signed [W:0]       SIG_OFF = (W + 1)'(128);
    localparam logic signed [W:0]       SIG_MAX = (W + 1)'(256);

    typedef enum logic [1:0] {IDLE, ACCUM, ACT, OUT} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [AW-1:0]           cnt;
    logic [W-1:0]            y_reg;
    logic signed [W-1:0]     weight [LEN];
    logic signed [W-1:0]     bias;

    logic                    h_fire;
    logic signed [W-1:0]     sel_w;
    logic signed [W-1:0]     mul_w;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;

    logic signed [SUM_W-1:0] sum_v;
    logic signed [SUM_W-1:0] shifted;
    logic signed [W-1:0]     s_sat;
    logic signed [W:0]       sig_raw;
    logic [W-1:0]            y_next;

    assign h_fire = bus.h_valid && bus.h_ready;

    // Pick the weight addressed by the running element count.
    always_comb begin
        sel_w = weight[0];
        for (int i = 1; i < LEN; i++) begin
            if (cnt == AW'(i)) begin
                sel_w = weight[i];
            end
        end
    end

    // The first element always pairs with weight 0, whatever cnt holds.
    assign mul_w    = (state == IDLE) ? weight[0] : sel_w;
    assign prod     = bus.h_data * mul_w;
    assign prod_ext = ACC_W'(prod);

    // Bias add, rescale Q16.16 -> Q8.8 (floor), saturate, then hard sigmoid.
    always_comb begin
        sum_v   = SUM_W'(acc) + (SUM_W'(bias) <<< 8);
        shifted = sum_v >>> 8;
        if (shifted > S_MAX) begin
            s_sat = {1'b0, {(W - 1){1'b1}}};
        end else if (shifted < S_MIN) begin
            s_sat = {1'b1, {(W - 1){1'b0}}};
        end else begin
            s_sat = shifted[W-1:0];
        end
        sig_raw = (W + 1)'(s_sat >>> 2) + SIG_OFF;
        if (sig_raw < 0) begin
            y_next = '0;
        end else if (sig_raw > SIG_MAX) begin
            y_next = W'(256);
        end else begin
            y_next = sig_raw[W-1:0];
        end
    end

    // Weight/bias file: writable only while idle so a vector in flight sees stable parameters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LEN; i++) begin
                weight[i] <= '0;
            end
            bias <= '0;
        end else if (bus.wr_en && (state == IDLE)) begin
            for (int i = 0; i < LEN; i++) begin
                if (bus.wr_addr == AW'(i)) begin
                    weight[i] <= bus.wr_data;
                end
            end
            if (bus.wr_addr == AW'(LEN)) begin
                bias <= bus.wr_data;
            end
        end
    end

    // Control FSM: accumulate on each handshake, one activation cycle, then hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            y_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (h_fire) begin
                        acc   <= prod_ext;
                        cnt   <= AW'(1);
                        state <= (LEN == 1) ? ACT : ACCUM;
                    end
                end
                ACCUM: begin
                    if (h_fire) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + AW'(1);
                        if (cnt == AW'(LEN - 1)) begin
                            state <= ACT;
                        end
                    end
                end
                ACT: begin
                    y_reg <= y_next;
                    state <= OUT;
                end
                OUT: begin
                    if (bus.y_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.h_ready = (state == IDLE) || (state == ACCUM);
    assign bus.y_valid = (state == OUT);
    assign bus.busy    = (state != IDLE);
    assign bus.y_data  = y_reg;
endmodule

// File: tb/tb_dense_sigmoid.sv
// Self-checking bench for dense_sigmoid: arithmetic reference model,
// per-cycle result comparison, directed corner cases and a random phase.
module tb_dense_sigmoid;
    localparam int LEN = 4;
    localparam int W   = 16;
    localparam int AW  = $clog2(LEN + 1);

    typedef int vec_t [LEN];

    logic clk = 1'b0;
    logic rst;

    int   total = 0;
    int   bad   = 0;
    vec_t m_w;
    int   m_b;
    int   exp_q [$];

    dense_sigmoid_if #(.LEN(LEN), .W(W)) bus ();

    dense_sigmoid #(.LEN(LEN), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    // Reference: real-valued dot product in Q16.16, floor to Q8.8, saturate, hard sigmoid.
    function automatic int model_y(input vec_t hv, input vec_t wv, input int b);
        longint num = 0;
        longint s;
        longint t;
        for (int i = 0; i < LEN; i++) begin
            num += longint'(hv[i]) * longint'(wv[i]);
        end
        num += longint'(b) * 256;
        s = floor_div(num, 256);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        t = floor_div(s, 4) + 128;
        if (t < 0) t = 0;
        if (t > 256) t = 256;
        return int'(t);
    endfunction

    function automatic int rand_val(input int mag);
        return int'($urandom_range(0, 2 * mag)) - mag;
    endfunction

    // Result checker: whenever a result is presented it must match the model's oldest entry.
    always @(negedge clk) begin
        if (!rst && bus.y_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_y_valid", 1, 0);
            end else begin
                checkOutput("y_data", int'(bus.y_data), exp_q[0]);
                checkOutput("out_h_ready", bus.h_ready, 0);
                checkOutput("out_busy", bus.busy, 1);
                if (bus.y_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic resetPulse();
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.h_valid = 1'b0;
        bus.h_data  = '0;
        bus.y_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < LEN; i++) m_w[i] = 0;
        m_b = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        checkOutput("rst_y_valid", bus.y_valid, 0);
        checkOutput("rst_y_data", int'(bus.y_data), 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_h_ready", bus.h_ready, 1);
    endtask

    task automatic writeParam(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = W'(data);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        if (addr < LEN) m_w[addr] = data;
        else if (addr == LEN) m_b = data;
    endtask

    task automatic writeAll(input vec_t wv, input int b);
        for (int i = 0; i < LEN; i++) writeParam(i, wv[i]);
        writeParam(LEN, b);
    endtask

    task automatic sendVector(input vec_t hv, input int count, input int max_gap);
        int gap;
        int waits;
        for (int i = 0; i < count; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bus.h_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            bus.h_valid = 1'b1;
            bus.h_data  = W'(hv[i]);
            waits = 0;
            while (!bus.h_ready && waits < 20) begin
                @(posedge clk);
                #1;
                waits++;
            end
            if (!bus.h_ready) checkOutput("h_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        bus.h_valid = 1'b0;
        if (count == LEN) begin
            exp_q.push_back(model_y(hv, m_w, m_b));
            checkOutput("act_y_valid", bus.y_valid, 0);
            checkOutput("act_h_ready", bus.h_ready, 0);
            checkOutput("act_busy", bus.busy, 1);
            @(posedge clk);
            #1;
            checkOutput("latency_y_valid", bus.y_valid, 1);
        end
    endtask

    task automatic collectResult(input int hold, input bit poke, input int expv);
        bus.y_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (poke) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = AW'(k % (LEN + 1));
                bus.wr_data = 16'h1234;
                bus.h_valid = 1'b1;
                bus.h_data  = 16'h0100;
            end
            @(posedge clk);
            #1;
            checkOutput("hold_y_valid", bus.y_valid, 1);
            checkOutput("hold_y_data", int'(bus.y_data), expv);
            checkOutput("hold_h_ready", bus.h_ready, 0);
            checkOutput("hold_busy", bus.busy, 1);
        end
        bus.wr_en   = 1'b0;
        bus.h_valid = 1'b0;
        bus.y_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.y_ready = 1'b0;
        checkOutput("y_valid_drop", bus.y_valid, 0);
        checkOutput("idle_busy", bus.busy, 0);
    endtask

    task automatic applyStimulus(input vec_t hv, input int max_gap, input int hold,
                                 input bit poke, input string name, input int lit);
        int expv;
        expv = model_y(hv, m_w, m_b);
        sendVector(hv, LEN, max_gap);
        if (lit >= 0) checkOutput(name, int'(bus.y_data), lit);
        collectResult(hold, poke, expv);
    endtask

    // Hard stop if something wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t hv;
        vec_t wv;
        vec_t zero_w;
        int   n;

        resetPulse();

        // Pin the reference model with hand-worked values.
        zero_w = '{0, 0, 0, 0};
        checkOutput("pin_all_256", model_y('{256, 256, 256, 256}, '{256, 256, 256, 256}, 0), 256);
        checkOutput("pin_zero_w", model_y('{77, -90, 300, 5}, zero_w, 0), 128);
        checkOutput("pin_neg512", model_y('{-512, 0, 0, 0}, '{256, 0, 0, 0}, 0), 0);
        checkOutput("pin_300", model_y('{300, 0, 0, 0}, '{256, 0, 0, 0}, 0), 203);
        checkOutput("pin_floor", model_y('{-5, 0, 0, 0}, '{256, 0, 0, 0}, 0), 126);
        checkOutput("pin_bias", model_y('{0, 0, 0, 0}, zero_w, 512), 256);

        // All weights 1.0, h all 1.0.
        writeAll('{256, 256, 256, 256}, 0);
        applyStimulus('{256, 256, 256, 256}, 0, 0, 1'b0, "all_ones_y", 256);

        // Zero weights give the midpoint; single negative term drives output to zero.
        writeAll(zero_w, 0);
        for (int i = 0; i < LEN; i++) hv[i] = rand_val(30000);
        applyStimulus(hv, 0, 0, 1'b0, "zero_w_y", 128);
        writeParam(0, 256);
        applyStimulus('{-512, 99, -7, 1000}, 0, 0, 1'b0, "neg_y", 0);

        // Saturation at both ends.
        writeAll('{32767, 32767, 32767, 32767}, 0);
        applyStimulus('{32767, 32767, 32767, 32767}, 0, 0, 1'b0, "sat_hi_y", 256);
        applyStimulus('{-32768, -32768, -32768, -32768}, 0, 0, 1'b0, "sat_lo_y", 0);

        // Result held for 5 cycles with writes and h offers ignored; next vector confirms.
        writeAll('{100, -50, 30, 20}, 64);
        applyStimulus('{200, -100, 50, 300}, 0, 5, 1'b1, "hold_first", -1);
        applyStimulus('{-150, 250, 10, -40}, 0, 0, 1'b0, "after_hold", -1);

        // Gapped delivery must match back-to-back.
        hv = '{123, -45, 210, -300};
        applyStimulus(hv, 0, 0, 1'b0, "b2b", -1);
        applyStimulus(hv, 4, 0, 1'b0, "gapped", model_y(hv, m_w, m_b));

        // Reset in the middle of a vector discards it and clears the parameters.
        writeAll('{256, 256, 256, 256}, 256);
        sendVector('{256, 256, 256, 256}, 2, 0);
        resetPulse();
        for (int i = 0; i < LEN; i++) hv[i] = rand_val(2000);
        applyStimulus(hv, 0, 0, 1'b0, "post_rst_y", 128);

        // Reset while a result is presented.
        writeAll('{256, 0, 0, 0}, 0);
        sendVector('{300, 0, 0, 0}, LEN, 0);
        checkOutput("pre_rst_out_y", int'(bus.y_data), 203);
        resetPulse();

        // Random phase.
        for (int it = 0; it < 25; it++) begin
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) begin
                int a;
                a = int'($urandom_range(0, (1 << AW) - 1));
                writeParam(a, (a == LEN) ? rand_val(2000) : rand_val(120));
            end
            for (int i = 0; i < LEN; i++) begin
                hv[i] = ($urandom_range(0, 7) == 0) ? rand_val(32767) : rand_val(300);
            end
            applyStimulus(hv, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          1'b0, "rand", -1);
        end

        checkOutput("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
